// File: rtl/loader_pkg.sv
// Shared types and constants for the stream-to-memory image loader.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } loader_state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;

  // 352x288 bytes packed four per word; shared with accelerator and controller.
  localparam int unsigned IMG_NUM_WORDS  = 25344;

endpackage

// File: rtl/stream_mem_loader_if.sv
// Image memory write port (port b) driven by the stream loader.
interface stream_mem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_dw;

  modport master (output mem_en, output mem_we, output mem_addr, output mem_dw);
  modport slave  (input  mem_en, input  mem_we, input  mem_addr, input  mem_dw);
endinterface

// File: rtl/stream_mem_loader_byte_packer.sv
// Packs received bytes little-endian into words; drops a partial word after an idle timeout.
module byte_packer
  import loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic [BYTE_W-1:0]   rx_byte,
  input  logic                rx_stb,
  output logic                word_valid_c,
  output logic [WORD_W-1:0]   word_c,
  output logic                timeout_c
);

  localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);
  localparam int unsigned LOW_W = (BYTES_PER_WORD - 1) * BYTE_W;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [LOW_W-1:0] low_bytes;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] idle_cnt;
  logic             take;

  assign take = enable && rx_stb;

  // The final byte completes the word combinationally so the write lands one cycle after its strobe.
  assign word_valid_c = take && (idx == LAST_IDX);
  assign word_c       = {rx_byte, low_bytes};
  assign timeout_c    = enable && !rx_stb && (idx != '0) &&
                        (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      low_bytes <= '0;
      idx       <= '0;
      idle_cnt  <= '0;
    end else if (take) begin
      idle_cnt <= '0;
      if (idx == LAST_IDX) begin
        idx <= '0;
      end else begin
        low_bytes[32'(idx) * BYTE_W +: BYTE_W] <= rx_byte;
        idx <= idx + IDX_W'(1);
      end
    end else if (timeout_c) begin
      idx      <= '0;
      idle_cnt <= '0;
    end else if (enable && (idx != '0)) begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stream_mem_loader.sv
// Loads NUM_WORDS packed words from the UART byte stream into image memory port b.
// Optional running word checksum enabled by macro LOADER_CHECKSUM_EN.
module stream_mem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned NUM_WORDS      = IMG_NUM_WORDS,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       arm,
  input  logic [BYTE_W-1:0]          data_stream_rx,
  input  logic                       data_stream_rx_stb,
  stream_mem_loader_if.master        mem,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun_err,
  output logic [WORD_W-1:0]          checksum
);

  localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);

  if (64'(BASE_ADDR) + 64'(NUM_WORDS) > (64'(1) << ADDR_WIDTH)) begin : g_addr_range_check
    $error("stream_mem_loader: BASE_ADDR + NUM_WORDS exceeds the address space");
  end
  if (NUM_WORDS == 0) begin : g_num_words_check
    $error("stream_mem_loader: NUM_WORDS must be at least 1");
  end

  loader_state_e      state;
  logic [CNT_W-1:0]   word_cnt;
  logic               start;
  logic               word_valid_c;
  logic [WORD_W-1:0]  word_c;
  logic               timeout_c;

  assign start = arm && ((state == IDLE) || (state == DONE));

  byte_packer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_packer (
    .clk          (clk),
    .reset        (reset),
    .enable       (busy),
    .clear        (start),
    .rx_byte      (data_stream_rx),
    .rx_stb       (data_stream_rx_stb),
    .word_valid_c (word_valid_c),
    .word_c       (word_c),
    .timeout_c    (timeout_c)
  );

  // Load sequencer with registered memory strobes and status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      word_cnt     <= '0;
      mem.mem_en   <= 1'b0;
      mem.mem_we   <= 1'b0;
      mem.mem_addr <= ADDR_WIDTH'(BASE_ADDR);
      mem.mem_dw   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      mem.mem_en <= 1'b0;
      mem.mem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            state       <= RECV;
            word_cnt    <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            overrun_err <= 1'b0;
          end
        end
        RECV: begin
          if (timeout_c) begin
            overrun_err <= 1'b1;
          end
          if (word_valid_c) begin
            state        <= WRITE;
            mem.mem_en   <= 1'b1;
            mem.mem_we   <= 1'b1;
            mem.mem_addr <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(word_cnt);
            mem.mem_dw   <= word_c;
          end
        end
        WRITE: begin
          if (word_cnt == CNT_W'(NUM_WORDS - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= RECV;
            word_cnt <= word_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Sum of written words, folded in as each write cycle completes.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      checksum <= '0;
    end else if (state == WRITE) begin
      checksum <= checksum + mem.mem_dw;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_stream_mem_loader.sv
// Directed bench for stream_mem_loader: queue-based reference model plus literal write checks.
module tb_stream_mem_loader;

  localparam int unsigned AW   = 16;
  localparam int unsigned BASE = 16;
  localparam int unsigned NUMW = 6;
  localparam int unsigned TMO  = 10;

  logic       clk;
  logic       reset;
  logic       arm;
  logic [7:0] rx;
  logic       stb;
  logic       busy;
  logic       done;
  logic       overrun_err;
  logic [31:0] checksum;

  stream_mem_loader_if #(.ADDR_WIDTH(AW)) mif ();

  stream_mem_loader #(
    .ADDR_WIDTH     (AW),
    .BASE_ADDR      (BASE),
    .NUM_WORDS      (NUMW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .arm                (arm),
    .data_stream_rx     (rx),
    .data_stream_rx_stb (stb),
    .mem                (mif),
    .busy               (busy),
    .done               (done),
    .overrun_err        (overrun_err),
    .checksum           (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes accumulate in a queue; a full queue of four becomes a write next cycle.
  logic        m_loading = 1'b0;
  logic        m_done    = 1'b0;
  logic        m_ovr     = 1'b0;
  int          m_words   = 0;
  int          m_idle    = 0;
  logic [31:0] m_sum     = '0;
  logic [7:0]  m_part[$];
  logic        m_was_loading;
  logic        m_wrote;
  logic        exp_we    = 1'b0;
  logic [AW-1:0] exp_addr = AW'(BASE);
  logic [31:0] exp_dw    = '0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_loading = 1'b0;
      m_done    = 1'b0;
      m_ovr     = 1'b0;
      m_words   = 0;
      m_idle    = 0;
      m_sum     = '0;
      m_part.delete();
      exp_we    = 1'b0;
      exp_addr  = AW'(BASE);
      exp_dw    = '0;
    end else begin
      m_was_loading = m_loading;
      m_wrote       = exp_we;
      exp_we        = 1'b0;
      if (m_wrote) begin
        m_sum = m_sum + exp_dw;
        m_words++;
        if (m_words == int'(NUMW)) begin
          m_loading = 1'b0;
          m_done    = 1'b1;
        end
      end
      if (m_was_loading) begin
        if (stb) begin
          m_part.push_back(rx);
          m_idle = 0;
          if (m_part.size() == 4) begin
            exp_dw   = {m_part[3], m_part[2], m_part[1], m_part[0]};
            exp_addr = AW'(BASE + m_words);
            exp_we   = 1'b1;
            m_part.delete();
          end
        end else if (m_part.size() != 0) begin
          m_idle++;
          if (m_idle == int'(TMO)) begin
            m_part.delete();
            m_idle = 0;
            m_ovr  = 1'b1;
          end
        end
      end else if (arm) begin
        m_loading = 1'b1;
        m_done    = 1'b0;
        m_ovr     = 1'b0;
        m_words   = 0;
        m_idle    = 0;
        m_sum     = '0;
        m_part.delete();
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("mem_en", 64'(mif.mem_en), 64'(exp_we));
    chk("mem_we", 64'(mif.mem_we), 64'(exp_we));
    chk("mem_addr", 64'(mif.mem_addr), 64'(exp_addr));
    chk("mem_dw", 64'(mif.mem_dw), 64'(exp_dw));
    chk("busy", 64'(busy), 64'(m_loading));
    chk("done", 64'(done), 64'(m_done));
    chk("overrun_err", 64'(overrun_err), 64'(m_ovr));
`ifdef LOADER_CHECKSUM_EN
    chk("checksum", 64'(checksum), 64'(m_sum));
`else
    chk("checksum", 64'(checksum), 64'd0);
`endif
  end

  // Observed writes for the literal checks.
  logic [AW-1:0] w_addr[$];
  logic [31:0]   w_dw[$];
  int            w_cyc[$];

  always @(negedge clk) begin
    if (mif.mem_we) begin
      w_addr.push_back(mif.mem_addr);
      w_dw.push_back(mif.mem_dw);
      w_cyc.push_back(cyc);
    end
  end

  task automatic clear_writes();
    w_addr.delete();
    w_dw.delete();
    w_cyc.delete();
  endtask

  task automatic send(input logic [7:0] b);
    rx  = b;
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic chk_write(input string name, input int i, input int addr, input logic [31:0] dw);
    if (w_addr.size() > i) begin
      chk({name, "_addr"}, 64'(w_addr[i]), 64'(addr));
      chk({name, "_dw"}, 64'(w_dw[i]), 64'(dw));
    end
  endtask

  int s_cyc;

  initial begin
    reset = 1'b1;
    arm   = 1'b0;
    stb   = 1'b0;
    rx    = '0;
    idle(2);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_addr", 64'(mif.mem_addr), 64'd16);
    chk("rst_dw", 64'(mif.mem_dw), 64'd0);
    chk("rst_cksum", 64'(checksum), 64'd0);
    reset = 1'b0;

    // Single word and its write latency.
    pulse_arm();
    clear_writes();
    send(8'h11); send(8'h22); send(8'h33);
    s_cyc = cyc;
    send(8'h44);
    idle(3);
    chk("t1_nwr", 64'(w_addr.size()), 64'd1);
    chk_write("t1", 0, 16, 32'h44332211);
    if (w_cyc.size() > 0) chk("t1_latency", 64'(w_cyc[0] - s_cyc), 64'd1);
    do_reset();

    // Full load with bytes on every cycle, including WRITE cycles.
    pulse_arm();
    clear_writes();
    for (int i = 0; i < 24; i++) send(8'(i));
    idle(1);
    chk("t2_nwr", 64'(w_addr.size()), 64'd6);
    chk_write("t2_w0", 0, 16, 32'h03020100);
    chk_write("t2_w1", 1, 17, 32'h07060504);
    chk_write("t2_w2", 2, 18, 32'h0B0A0908);
    chk_write("t2_w5", 5, 21, 32'h17161514);
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_busy", 64'(busy), 64'd0);
    if (w_cyc.size() == 6) chk("t2_done_lat", 64'(cyc - w_cyc[5]), 64'd1);
    for (int i = 0; i < 4; i++) send(8'(8'hE0 + i));
    idle(2);
    chk("t2_no_more_wr", 64'(w_addr.size()), 64'd6);
    chk("t2_done_held", 64'(done), 64'd1);

    // Timeout drops a partial word; a gap just under the limit does not.
    pulse_arm();
    clear_writes();
    chk("t3_done_clr", 64'(done), 64'd0);
    send(8'h01); send(8'h02);
    idle(TMO + 3);
    chk("t3_ovr", 64'(overrun_err), 64'd1);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    idle(1);
    chk("t3_nwr", 64'(w_addr.size()), 64'd1);
    chk_write("t3_w0", 0, 16, 32'hDDCCBBAA);
    send(8'hA1); send(8'hA2);
    idle(TMO - 2);
    send(8'hA3); send(8'hA4);
    idle(1);
    chk_write("t3_w1", 1, 17, 32'hA4A3A2A1);
    pulse_arm();
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    idle(1);
    chk_write("t3_w2", 2, 18, 32'h08070605);
    chk("t3_ovr_held", 64'(overrun_err), 64'd1);
    do_reset();

    // Reset mid-load, arm colliding with reset, then a fresh load.
    pulse_arm();
    clear_writes();
    for (int i = 0; i < 20; i++) send(8'(8'h40 + i));
    idle(1);
    chk("t4_nwr", 64'(w_addr.size()), 64'd5);
    reset = 1'b1;
    arm   = 1'b1;
    idle(1);
    reset = 1'b0;
    arm   = 1'b0;
    idle(1);
    chk("t4_rst_busy", 64'(busy), 64'd0);
    pulse_arm();
    chk("t4_arm_busy", 64'(busy), 64'd1);
    clear_writes();
    send(8'h5A); send(8'h5B); send(8'h5C); send(8'h5D);
    chk_write("t4_w0", 0, 16, 32'h5D5C5B5A);
    chk("t4_busy", 64'(busy), 64'd1);
    chk("t4_done", 64'(done), 64'd0);
    do_reset();

    // Checksum wraps modulo 2^32.
    pulse_arm();
    send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
    send(8'h02); send(8'h00); send(8'h00); send(8'h00);
    idle(1);
`ifdef LOADER_CHECKSUM_EN
    chk("t5_cksum", 64'(checksum), 64'h1);
`else
    chk("t5_cksum", 64'(checksum), 64'h0);
`endif
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
